pipe_reg_chain: RTL

- Parametrised successor to the single D flip-flop: a chain of DEPTH WIDTH-bit register stages with a valid/ready handshake on both ends.
- Per-stage valid bits, bubble collapsing, synchronous flush and an occupancy count.
- Used as the team's standard retiming/buffer slice between producer and consumer blocks.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_reg_slice.sv | 43 ++++
 rtl/pipe_reg_chain.sv | 98 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe_reg_chain retiming slice.
package pipe_pkg;

  // Ceiling log2 usable in constant expressions (port and localparam widths).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_slice.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
module pipe_reg_slice #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  // A load wins over a clear; the caller gates load when clear must dominate.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load) begin
      data_d = d;
      vld_d  = 1'b1;
    end else if (clear) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q = data_q;
  assign v = vld_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of DEPTH register slices with valid/ready on both ends, bubble
// collapsing, synchronous flush and an occupancy count.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data [DEPTH];
  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] count_d, count_q;

  // A stage advances when it holds a beat and the stage ahead is empty or moving.
  function automatic logic [DEPTH-1:0] calc_adv(input logic [DEPTH-1:0] v,
                                                input logic             ordy);
    logic [DEPTH-1:0] a;
    a = '0;
    a[DEPTH-1] = v[DEPTH-1] & ordy;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      a[i] = v[i] & (~v[i+1] | a[i+1]);
    end
    return a;
  endfunction

  always_comb begin
    adv      = calc_adv(vld, out_ready);
    pop      = adv[DEPTH-1];
    in_ready = reset & ~flush & (~vld[0] | adv[0]);
    accept   = in_valid & in_ready;
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
    logic [WIDTH-1:0] src_data;
    logic             src_adv;

    if (g == 0) begin : g_in
      assign src_data = in_data;
      assign src_adv  = accept;
    end else begin : g_mid
      assign src_data = data[g-1];
      assign src_adv  = adv[g-1];
    end

    // Flush dominates every load; data registers simply hold.
    pipe_reg_slice #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slice (
      .clk   (clk),
      .rst_n (reset),
      .load  (~flush & src_adv),
      .clear (flush | adv[g]),
      .d     (src_data),
      .q     (data[g]),
      .v     (vld[g])
    );
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];

endmodule
